rr_arbiter_8: RTL and testbench

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/arb_pkg.sv | 7 +
 rtl/arb_prio_enc8.sv | 16 +
 rtl/rr_arbiter_8.sv | 87 ++++++++
 tb/tb_rr_arbiter_8.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and sizing for the round-robin arbiter.
// Contents: state_e (IDLE/GRANT), N_REQ requester count, IDX_W index width.
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;
endpackage

// File: rtl/arb_prio_enc8.sv
// arb_prio_enc8: 8-input priority encoder, highest set index wins.
// Ports: en_i gates the encoder (output 0 when low), req_i request bits,
//        idx_o binary index of the highest set bit (0 when none).
module arb_prio_enc8
    import arb_pkg::*;
(
    input  logic             en_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [IDX_W-1:0] idx_o
);
    always_comb begin
        idx_o = '0;
        for (int k = 0; k < N_REQ; k++)
            if (en_i && req_i[k]) idx_o = IDX_W'(k);
    end
endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter with hold limit and timeout pulse.
// Ports: clk clock, rst_n sync active-low reset, en_i enable, req_i requests,
//        release_i holder done, grant_o one-hot grant, grant_id_o index,
//        grant_valid_o grant active, timeout_o hold-limit revoke pulse.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             release_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] grant_id_o,
    output logic             grant_valid_o,
    output logic             timeout_o
);
    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] id_q, id_d, last_q, last_d;
    logic [7:0]       hold_q, hold_d;
    logic             timeout_q, timeout_d;
    logic [N_REQ-1:0] masked;
    logic [IDX_W-1:0] idx_m, idx_u, win;
    logic             expire, keep;

    // Requesters below the last winner get first pick; otherwise wrap to all.
    assign masked = req_i & ((N_REQ'(1) << last_q) - N_REQ'(1));

    arb_prio_enc8 u_enc_m (.en_i(en_i), .req_i(masked), .idx_o(idx_m));
    arb_prio_enc8 u_enc_u (.en_i(en_i), .req_i(req_i),  .idx_o(idx_u));

    assign win    = (|masked) ? idx_m : idx_u;
    assign expire = hold_q >= 8'(MAX_HOLD);
    assign keep   = en_i && !release_i && req_i[id_q] && !expire;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        id_d      = id_q;
        last_d    = last_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            if (en_i && |req_i) begin
                state_d = GRANT;
                grant_d = N_REQ'(1) << win;
                id_d    = win;
                last_d  = win;
                hold_d  = 8'd1;
            end
        end else if (keep) begin
            hold_d = hold_q + 8'd1;
        end else begin
            state_d   = IDLE;
            grant_d   = '0;
            id_d      = '0;
            // A simultaneous release takes precedence over expiry.
            timeout_d = expire && !release_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            last_q    <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_id_o    = id_q;
    assign grant_valid_o = state_q == GRANT;
    assign timeout_o     = timeout_q;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: scoreboard bench for rr_arbiter_8 with MAX_HOLD=4.
module tb_rr_arbiter_8;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n, en, rel;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid, timeout;

    rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .req_i(req), .release_i(rel),
        .grant_o(grant), .grant_id_o(grant_id), .grant_valid_o(grant_valid),
        .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] g;
        logic [2:0] id;
        logic       v;
        logic       to;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    bit m_busy;
    bit m_to;
    int m_id, m_last, m_hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: search L-1 down to 0, then wrap 7 down to L.
    function automatic int pick(input logic [7:0] r, input int last);
        int c;
        for (int o = 1; o <= 8; o++) begin
            c = (last - o) & 7;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    task automatic model_step();
        exp_t e;
        if (!rst_n) begin
            m_busy = 0; m_id = 0; m_last = 0; m_hold = 0; m_to = 0;
        end else if (!m_busy) begin
            m_to = 0;
            if (en && req != 8'h00) begin
                m_id = pick(req, m_last); m_last = m_id; m_busy = 1; m_hold = 1;
            end
        end else if (rel || !req[m_id] || !en || m_hold == MH) begin
            m_to = (m_hold == MH) && !rel;
            m_busy = 0; m_id = 0;
        end else begin
            m_hold++; m_to = 0;
        end
        e.g  = m_busy ? 8'(1 << m_id) : 8'h00;
        e.id = 3'(m_id);
        e.v  = m_busy;
        e.to = m_to;
        q.push_back(e);
    endtask

    task automatic cyc(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk);
            #1;
            e = q.pop_front();
            check("grant", grant, e.g);
            check("grant_id", grant_id, e.id);
            check("grant_valid", grant_valid, e.v);
            check("timeout", timeout, e.to);
            check("onehot0", $onehot0(grant), 1);
        end
    endtask

    int gcnt, tcnt;
    int seq[9];

    initial begin
        seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        rst_n = 1'b0; en = 1'b0; rel = 1'b0; req = 8'h00;
        cyc(2);
        // first arbitration is fixed priority, then rotates below the last winner
        rst_n = 1'b1; en = 1'b1; req = 8'h84;
        cyc(1);
        check("t30_first_id", grant_id, 7);
        check("t30_first_grant", grant, 8'h80);
        rel = 1'b1; cyc(1);
        check("t30_idle", grant_valid, 0);
        rel = 1'b0; cyc(1);
        check("t30_second_id", grant_id, 2);
        rel = 1'b1; cyc(1);
        rel = 1'b0; req = 8'h00; cyc(1);
        // full rotation from reset
        rst_n = 1'b0; cyc(1);
        rst_n = 1'b1; req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            rel = 1'b0; cyc(1);
            check("t31_seq", grant_id, 32'(seq[i]));
            rel = 1'b1; cyc(1);
            check("t31_gap", grant_valid, 0);
        end
        // hold limit expiry and re-grant
        rel = 1'b0; req = 8'h00; cyc(1);
        req = 8'h10; gcnt = 0; tcnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            gcnt += int'(grant_valid);
            tcnt += int'(timeout);
        end
        check("t32_grant_cycles", gcnt, 10);
        check("t32_timeouts", tcnt, 2);
        req = 8'h00; cyc(2);
        // dropped request releases; other requests ignored while granted
        req = 8'h20; cyc(1);
        check("t33_id5", grant_id, 5);
        req = 8'h28; cyc(2);
        check("t33_hold5", grant_id, 5);
        req = 8'h08; cyc(1);
        check("t33_drop", grant, 8'h00);
        check("t33_no_timeout", timeout, 0);
        cyc(1);
        check("t33_id3", grant_id, 3);
        req = 8'h00; cyc(1);
        // enable and reset revoke a live grant
        req = 8'hFF; cyc(1);
        en = 1'b0; cyc(1);
        check("t34_en_revoke", grant, 8'h00);
        cyc(3);
        check("t34_en_block", grant_valid, 0);
        en = 1'b1; cyc(1);
        rst_n = 1'b0; cyc(1);
        check("t34_rst_grant", grant, 8'h00);
        rst_n = 1'b1; cyc(1);
        check("t34_rst_prio", grant_id, 7);
        req = 8'h00; cyc(1);
        // release coinciding with expiry is a plain release
        req = 8'h10; cyc(4);
        rel = 1'b1; cyc(1);
        check("t35_timeout", timeout, 0);
        rel = 1'b0; req = 8'h00; cyc(1);
        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            req   = 8'($urandom);
            en    = ($urandom_range(0, 9) != 0);
            rel   = ($urandom_range(0, 5) == 0);
            rst_n = ($urandom_range(0, 49) != 0);
            cyc(1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
